// File: rtl/dram_cmd_queue.sv
// dram_cmd_queue
//   Show-ahead command FIFO between the host command port and the DRAM
//   scheduler. The head entry is presented unpacked and tagged with a row-hit
//   flag taken from a per-bank open-row table. The table and the saturating
//   hit/miss statistics are updated as entries retire.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     command push handshake
//   in_cmd[CMD_W]         packed command, MSB->LSB:
//                         r_w, rsvd, row, rsvd, bl, rsvd, ap, col, bank
//   out_valid/out_ready   head pop handshake
//   out_r_w..out_ap       unpacked head fields (zero while empty)
//   out_row_hit           head row is already open in its bank
//   prech_all             pulse: every bank was precharged externally
//   count                 current occupancy
//   hit_cnt/miss_cnt      saturating retire statistics
module dram_cmd_queue #(
    parameter int ROW_W  = 13,
    parameter int COL_W  = 10,
    parameter int BANK_W = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    localparam int CMD_W = ROW_W + COL_W + BANK_W + 6,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CMD_W-1:0]  in_cmd,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_r_w,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic [BANK_W-1:0] out_bank,
    output logic              out_bl,
    output logic              out_ap,
    output logic              out_row_hit,
    input  logic              prech_all,
    output logic [OCC_W-1:0]  count,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int NBANK = 2 ** BANK_W;
    localparam int PTR_W = $clog2(DEPTH);

    // Bit positions inside in_cmd, counted from the LSB
    localparam int COL_LSB = BANK_W;
    localparam int AP_BIT  = BANK_W + COL_W;
    localparam int BL_BIT  = AP_BIT + 2;
    localparam int ROW_LSB = AP_BIT + 4;
    localparam int RW_BIT  = CMD_W - 1;

    localparam logic [OCC_W-1:0] FULL    = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Only the defined fields are stored; reserved bits are dropped here.
    typedef struct packed {
        logic              r_w;
        logic [ROW_W-1:0]  row;
        logic              bl;
        logic              ap;
        logic [COL_W-1:0]  col;
        logic [BANK_W-1:0] bank;
    } ent_t;

    ent_t             mem [DEPTH];
    ent_t             in_ent;
    ent_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    logic             bank_open [NBANK];
    logic [ROW_W-1:0] open_row  [NBANK];

    // Reserved command bits are intentionally ignored.
    logic rsvd_unused;
    assign rsvd_unused = ^{in_cmd[RW_BIT-1], in_cmd[ROW_LSB-1], in_cmd[AP_BIT+1]};

    assign in_ent = '{
        r_w:  in_cmd[RW_BIT],
        row:  in_cmd[ROW_LSB +: ROW_W],
        bl:   in_cmd[BL_BIT],
        ap:   in_cmd[AP_BIT],
        col:  in_cmd[COL_LSB +: COL_W],
        bank: in_cmd[BANK_W-1:0]
    };

    // No pass-through when full: a same-cycle pop does not open a slot.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Show-ahead head, forced to zero while the queue is empty
    assign head     = out_valid ? mem[rd_ptr] : '0;
    assign out_r_w  = head.r_w;
    assign out_row  = head.row;
    assign out_col  = head.col;
    assign out_bank = head.bank;
    assign out_bl   = head.bl;
    assign out_ap   = head.ap;

    // Uses the table as it stands before the edge that retires the head
    assign out_row_hit = out_valid && bank_open[out_bank] &&
                         (open_row[out_bank] == out_row);

    // Storage needs no reset: out_valid gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Per-bank open-row tracking. prech_all wins over a retiring command
    // that would otherwise leave its bank open.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic sel;
        assign sel = pop && (out_bank == BANK_W'(b));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bank_open[b] <= 1'b0;
                open_row[b]  <= '0;
            end else begin
                if (prech_all)
                    bank_open[b] <= 1'b0;
                else if (sel)
                    bank_open[b] <= !out_ap;
                if (sel && !out_ap)
                    open_row[b] <= out_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (pop) begin
            if (out_row_hit) begin
                if (hit_cnt != CNT_MAX)
                    hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
                if (miss_cnt != CNT_MAX)
                    miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dram_cmd_queue.sv
module tb_dram_cmd_queue;

    typedef struct packed {
        logic        r_w;
        logic [12:0] row;
        logic [9:0]  col;
        logic [2:0]  bank;
        logic        bl;
        logic        ap;
        logic        hit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, prech_all;
    logic [31:0] in_cmd;
    logic        in_ready, out_valid, out_r_w, out_bl, out_ap, out_row_hit;
    logic [12:0] out_row;
    logic [9:0]  out_col;
    logic [2:0]  out_bank;
    logic [3:0]  count;
    logic [15:0] hit_cnt, miss_cnt;

    // Second instance with narrow counters for the saturation check
    logic        s_in_valid, s_out_ready;
    logic [31:0] s_in_cmd;
    logic        s_in_ready, s_out_valid, s_out_r_w, s_out_bl, s_out_ap, s_out_row_hit;
    logic [12:0] s_out_row;
    logic [9:0]  s_out_col;
    logic [2:0]  s_out_bank;
    logic [3:0]  s_count;
    logic [1:0]  s_hit_cnt, s_miss_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dram_cmd_queue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cmd(in_cmd),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_r_w(out_r_w), .out_row(out_row), .out_col(out_col),
        .out_bank(out_bank), .out_bl(out_bl), .out_ap(out_ap),
        .out_row_hit(out_row_hit), .prech_all(prech_all), .count(count),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    dram_cmd_queue #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_cmd(s_in_cmd),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_r_w(s_out_r_w), .out_row(s_out_row), .out_col(s_out_col),
        .out_bank(s_out_bank), .out_bl(s_out_bl), .out_ap(s_out_ap),
        .out_row_hit(s_out_row_hit), .prech_all(1'b0), .count(s_count),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    // Reserved bits are driven to 1 so that a design leaking them is caught.
    function automatic logic [31:0] mk(input logic r_w, input logic [12:0] row,
                                       input logic bl, input logic ap,
                                       input logic [9:0] col, input logic [2:0] bank);
        return {r_w, 1'b1, row, 1'b1, bl, 1'b1, ap, col, bank};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One push cycle; the expected head view (incl. hit flag at retire) is queued.
    task automatic push(input logic r_w, input logic [12:0] row, input logic bl,
                        input logic ap, input logic [9:0] col, input logic [2:0] bank,
                        input logic hit);
        exp_t e;
        e = '{r_w: r_w, row: row, col: col, bank: bank, bl: bl, ap: ap, hit: hit};
        in_valid = 1'b1;
        in_cmd   = mk(r_w, row, bl, ap, col, bank);
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every retiring head is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t act, exp;
            act = '{r_w: out_r_w, row: out_row, col: out_col, bank: out_bank,
                    bl: out_bl, ap: out_ap, hit: out_row_hit};
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL head_unexpected: got %0h expected none", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL head: got rw=%0d row=%0d col=%0d bank=%0d bl=%0d ap=%0d hit=%0d expected rw=%0d row=%0d col=%0d bank=%0d bl=%0d ap=%0d hit=%0d",
                             act.r_w, act.row, act.col, act.bank, act.bl, act.ap, act.hit,
                             exp.r_w, exp.row, exp.col, exp.bank, exp.bl, exp.ap, exp.hit);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; out_ready = 1'b0; prech_all = 1'b0;
        s_in_valid = 1'b0; s_in_cmd = '0; s_out_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_row", 32'(out_row), 0);
        chk("rst_out_col", 32'(out_col), 0);
        chk("rst_hit", 32'(hit_cnt), 0);
        chk("rst_miss", 32'(miss_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Row hits in bank 2: rows 5,5,7,7 -> miss,hit,miss,hit
        out_ready = 1'b1;
        push(0, 5, 0, 0, 11, 2, 0);
        push(0, 5, 0, 0, 12, 2, 1);
        push(0, 7, 0, 0, 13, 2, 0);
        push(0, 7, 1, 0, 14, 2, 1);
        tick(); tick();
        chk("t1_hit", 32'(hit_cnt), 2);
        chk("t1_miss", 32'(miss_cnt), 2);

        // Fill to 8 with the head stalled; pointers wrap. All retire as misses.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            push(1'(i & 1), 13'(100 + i), 1'(~i & 1), 1'(i & 1), 10'(10 * i + 3), 3'(i), 0);
        chk("full_count", 32'(count), 8);
        chk("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_cmd   = mk(1, 999, 1, 1, 999, 7);
        tick();
        in_valid = 1'b0;
        chk("refused_count", 32'(count), 8);
        out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_out_col", 32'(out_col), 0);
        chk("drain_out_bank", 32'(out_bank), 0);
        chk("t2_miss", 32'(miss_cnt), 10);

        // Auto-precharge closes the bank: row 3 bank 1 -> miss, hit(ap), miss
        out_ready = 1'b1;
        push(0, 3, 0, 0, 21, 1, 0);
        push(1, 3, 0, 1, 22, 1, 1);
        push(0, 3, 0, 0, 23, 1, 0);
        tick(); tick();
        chk("t3_hit", 32'(hit_cnt), 3);
        chk("t3_miss", 32'(miss_cnt), 12);

        // prech_all on the edge of a hit pop: hit still counted, bank closed after
        out_ready = 1'b0;
        push(0, 9, 0, 0, 31, 4, 0);
        push(0, 9, 0, 0, 32, 4, 1);
        push(0, 9, 0, 0, 33, 4, 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t4_head_hit", 32'(out_row_hit), 1);
        out_ready = 1'b1; prech_all = 1'b1; tick(); out_ready = 1'b0; prech_all = 1'b0;
        chk("t4_after_prech_hit", 32'(out_row_hit), 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t4_count", 32'(count), 0);
        chk("t4_hit", 32'(hit_cnt), 4);
        chk("t4_miss", 32'(miss_cnt), 14);

        // Streaming at occupancy 3 for 20 cycles
        for (int i = 0; i < 3; i++)
            push(0, 13'(200 + i), 0, 1, 10'(i), 5, 0);
        out_ready = 1'b1;
        for (int i = 3; i < 23; i++) begin
            push(1, 13'(200 + i), 1, 1, 10'(i), 5, 0);
            chk("stream_count", 32'(count), 3);
        end
        repeat (4) tick();
        out_ready = 1'b0;
        chk("t5_count", 32'(count), 0);
        chk("t5_miss", 32'(miss_cnt), 37);

        // Asynchronous reset mid-cycle with 4 entries queued
        for (int i = 0; i < 4; i++)
            push(0, 13'(300 + i), 0, 0, 10'(i), 6, 0);
        chk("pre_rst_count", 32'(count), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_hit", 32'(hit_cnt), 0);
        chk("arst_miss", 32'(miss_cnt), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        // Table was cleared: bank 2 row 7 is now a miss
        out_ready = 1'b1;
        push(0, 7, 0, 0, 41, 2, 0);
        tick(); tick();
        out_ready = 1'b0;
        chk("post_rst_hit", 32'(hit_cnt), 0);
        chk("post_rst_miss", 32'(miss_cnt), 1);

        // Narrow counter saturation: 1 miss then 5 hits on bank 0 row 1
        s_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_in_valid = 1'b1;
            s_in_cmd   = mk(0, 1, 0, 0, 10'(i), 0);
            tick();
        end
        s_in_valid = 1'b0;
        tick(); tick();
        chk("sat_hit", 32'(s_hit_cnt), 3);
        chk("sat_miss", 32'(s_miss_cnt), 1);
        chk("sat_count", 32'(s_count), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
